fixed_mul_seq: RTL and testbench

FIXED_MUL_SEQ -- requirements
Module: fixed_mul_seq

---
 rtl/fixed_mul_seq.sv | 122 ++++++++++++
 tb/tb_fixed_mul_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mul_seq.sv
// Sequential unsigned fixed-point multiplier: {q,f} (Q WIDTH.WIDTH) times integer d.
// One shift-add step per cycle, WIDTH cycles per product, valid/ready on both sides.
module fixed_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] nf,
  output logic             ovf
);

  localparam int unsigned AW = 3 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] nf_q, nf_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    sum;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      nf_q        <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      nf_q        <= nf_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, shift-add step and result capture
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    nf_d     = nf_q;
    ovf_d    = ovf_q;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = AW'({q, f});
          mplier_d = d;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last step: publish the finished accumulator straight from the adder
          n_d     = sum[2*WIDTH-1:WIDTH];
          nf_d    = sum[WIDTH-1:0];
          ovf_d   = |sum[AW-1:2*WIDTH];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign nf        = nf_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Scoreboard bench for fixed_mul_seq (WIDTH=8): directed corner cases plus
// randomized accepts with random output stalls, checked against an arithmetic model.
module tb_fixed_mul_seq;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] nf;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q, f, d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] n, nf;
  logic       ovf;

  int   tests = 0;
  int   fails = 0;
  int   res_cnt = 0;
  res_t sb[$];
  res_t last_res;
  logic or_man = 1'b1;
  logic rnd_en = 1'b0;

  fixed_mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .f(f), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .n(n), .nf(nf), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : or_man;
  end

  initial out_ready = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact product of the 16-bit fixed-point value and d, then split.
  function automatic res_t model(input logic [7:0] qq, input logic [7:0] ff, input logic [7:0] dd);
    longint unsigned mc, p;
    res_t r;
    mc    = longint'(qq) * 256 + longint'(ff);
    p     = mc * longint'(dd);
    r.n   = 8'((p / 256) % 256);
    r.nf  = 8'(p % 256);
    r.ovf = (p >= 65536);
    return r;
  endfunction

  task automatic send(input logic [7:0] qq, input logic [7:0] ff, input logic [7:0] dd);
    bit got = 1'b0;
    q = qq; f = ff; d = dd;
    in_valid = 1'b1;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end else begin
      sb.push_back(model(qq, ff, dd));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q = 8'($urandom); f = 8'($urandom); d = 8'($urandom);
  endtask

  task automatic wait_result(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (res_cnt >= target) return;
    end
    tests++;
    fails++;
    $display("FAIL result_timeout: got %0d results expected %0d", res_cnt, target);
  endtask

  // Monitor: pops on every output handshake, checks hold stability under stall.
  initial begin
    logic        stall_pend;
    logic [16:0] snap;
    res_t        exp;
    stall_pend = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'({n, nf, ovf}), 32'(snap));
        end
        stall_pend = out_valid && !out_ready;
        snap = {n, nf, ovf};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got n=%0h nf=%0h ovf=%0b expected none", n, nf, ovf);
          end else begin
            exp = sb.pop_front();
            chk("result", 32'({n, nf, ovf}), 32'(exp));
          end
          last_res = {n, nf, ovf};
          res_cnt++;
        end
      end
    end
  end

  initial begin
    int          c0;
    logic [16:0] hold;
    rst = 1'b1; in_valid = 1'b0; q = '0; f = '0; d = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'({n, nf, ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    c0 = res_cnt; send(8'd3, 8'h80, 8'd5); wait_result(c0 + 1);
    chk("basic", 32'(last_res), 32'({8'd17, 8'h80, 1'b0}));
    c0 = res_cnt; send(8'hFF, 8'h00, 8'd2); wait_result(c0 + 1);
    chk("ovf_x2", 32'(last_res), 32'({8'hFE, 8'h00, 1'b1}));
    c0 = res_cnt; send(8'hFF, 8'hFF, 8'hFF); wait_result(c0 + 1);
    chk("ovf_max", 32'(last_res), 32'({8'hFF, 8'h01, 1'b1}));

    // Zero multiplier: full latency, then backpressure on the held result
    or_man = 1'b0;
    send(8'h12, 8'h34, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'(j == 8));
      chk("lat_in_ready", 32'(in_ready), 32'd0);
    end
    hold = {n, nf, ovf};
    chk("zero_data", 32'(hold), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k % 2 == 1);
      q = 8'($urandom); f = 8'($urandom); d = 8'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'({n, nf, ovf}), 32'(hold));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    or_man = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("zero_result", 32'(last_res), 32'd0);

    // Reset in RUN cycle 4 with a nonzero previous result held
    @(posedge clk);
    #1;
    c0 = res_cnt; send(8'h12, 8'h34, 8'd3); wait_result(c0 + 1);
    send(8'h40, 8'h11, 8'h99);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'({n, nf, ovf}), 32'd0);
    sb.delete();
    c0 = res_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    chk("no_stale", 32'(res_cnt), 32'(c0));
    #1;
    send(8'd1, 8'd0, 8'd7); wait_result(c0 + 1);
    chk("after_rst", 32'(last_res), 32'({8'd7, 8'd0, 1'b0}));

    // Random regression with random output stalls
    rnd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    chk("drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
